periph_bus_arbiter: RTL and testbench
=====================================

Name: periph_bus_arbiter

Overview:
- Two-master arbiter in front of the single-port memory-mapped peripheral slave interface used by the timer block and similar MMIO registers.
- Master 0 is the CPU load/store port. Master 1 is the debug/DMA port.
- Serialises accesses, gives each slave exactly one write-strobe cycle per transaction, and returns a registered response with read data and a decode-error flag.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (master 0 wins).
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  master 0 request; sampled only in IDLE
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_wstrb  in  DATA_W/8  master 0 byte enables; all-zero means read
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  one-cycle response pulse
- m0_rdata  out  DATA_W  read data; 0 for writes
- m0_err  out  1  slave did not decode the address; valid with rvalid
- m1_req, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as master 0, for master 1
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave byte enables
- s_read_en  out  1  slave read enable
- s_rdata  in  DATA_W  slave combinational read data
- s_addr_valid  in  1  slave address-hit indication (combinational)
- busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high.
  - state=IDLE, last_grant=1 so master 0 wins the first tie.
  - All gnt/rvalid/err = 0, all rdata = 0, busy = 0.
  - s_wstrb = 0 and s_read_en = 0 combinationally whenever rst=1, even if state is ACCESS.
- FSM has three states:
  - IDLE -> ACCESS when any req=1.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- IDLE:
  - Winner chosen combinationally. gnt for the winner is asserted in the same cycle; at most one gnt is high.
  - On that edge, latch owner, addr, wdata and wstrb.
  - Round-robin: if both request, grant the master that is not last_grant; a single requester always wins. last_grant updates on grant.
  - ARB_MODE=1: master 0 always wins ties.
- ACCESS (exactly one cycle):
  - s_addr/s_wdata/s_wstrb come from the latch. s_read_en = (latched wstrb == 0).
  - Register s_rdata (forced to 0 for writes) and err = !s_addr_valid.
- RESP:
  - Owner's rvalid=1 for exactly one cycle, with its rdata and err. The other master's rvalid stays 0.
  - rdata/err hold their value until the owner's next response.
- Outside ACCESS: s_wstrb = 0, s_read_en = 0, s_addr = 0, s_wdata = 0. Slave registers must never see a write strobe outside ACCESS.
- Latency: gnt at cycle T, slave access at T+1, rvalid at T+2. Next grant possible at T+3. Peak throughput is 1 transaction per 3 cycles.
- Master rules:
  - Hold req/addr/wdata/wstrb stable until gnt.
  - req is ignored outside IDLE.
  - req held high after gnt issues a new transaction at the next IDLE.
- A partial strobe (e.g. 4'b0011) is a write and is passed through unchanged.
- Reset mid-transaction: abort. No rvalid is produced and no slave strobe is issued in the reset cycle. The master must re-request.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, ACCESS, RESP.
  - ARB_RR=0 and ARB_FIXED=1 constants.
  - Peripheral base-address constants, including timer base 0x0200_0000.
- One sub-module, rr_arb2: two-input round-robin/fixed-priority grant logic with the last_grant register. Everything else stays in the top.

Test Plan:
- Master 0 reads 0x0200_BFF8 with s_addr_valid=1 and s_rdata=0x0000_1234 -> m0_gnt at T, s_read_en=1 only at T+1, m0_rvalid at T+2 with rdata=0x1234, err=0.
- Master 1 writes 0x0200_4000, wdata=0xDEAD_BEEF, wstrb=4'hF -> s_wstrb=4'hF for exactly one cycle; m1_rvalid with rdata=0, err=0.
- Both requesting continuously, ARB_MODE=0 -> grant order m0, m1, m0, m1, with grants 3 cycles apart.
- Same stimulus with ARB_MODE=1 -> m0 granted every time; m1 is never granted.
- Read of 0x0300_0000 with s_addr_valid=0 -> rvalid with err=1, rdata=0.
- rst asserted in ACCESS during a write -> s_wstrb=0 that cycle, no rvalid; after rst, state=IDLE and the next tie grants m0.

Source files
------------

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package periph_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Peripheral base addresses on the MMIO bus
  localparam logic [31:0] TIMER_BASE = 32'h0200_0000;
  localparam logic [31:0] UART_BASE  = 32'h0201_0000;
  localparam logic [31:0] GPIO_BASE  = 32'h0202_0000;

endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// Two-input grant logic, round-robin or fixed priority, with last-grant state.
module rr_arb2
  import periph_bus_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Winner selection; a tie goes to whichever master did not win last
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ((ARB_MODE == ARB_FIXED) || last_q) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o[1]) begin
        last_d = 1'b1;
      end else if (gnt_o[0]) begin
        last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Serialises two masters onto one MMIO slave port: grant, one access cycle,
// then a registered response to the owning master.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_read_en,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_addr_valid,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state_q,  state_d;
  logic                owner_q,  owner_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [STRB_W-1:0]   wstrb_q,  wstrb_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [1:0]          err_q,    err_d;
  logic [1:0]          gnt;
  logic                acc_c;
  logic [DATA_W-1:0]   resp_data_c;

  rr_arb2 #(
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({m1_req, m0_req}),
    .en_i  ((state_q == IDLE) && !rst),
    .gnt_o (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Slave side is only driven during ACCESS, and never while in reset
  assign acc_c       = (state_q == ACCESS) && !rst;
  assign s_addr      = acc_c ? addr_q  : '0;
  assign s_wdata     = acc_c ? wdata_q : '0;
  assign s_wstrb     = acc_c ? wstrb_q : '0;
  assign s_read_en   = acc_c && (wstrb_q == '0);
  assign resp_data_c = ((wstrb_q == '0) && s_addr_valid) ? s_rdata : '0;

  assign busy      = (state_q != IDLE);
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = ACCESS;
          owner_d = gnt[1];
          addr_d  = gnt[1] ? m1_addr  : m0_addr;
          wdata_d = gnt[1] ? m1_wdata : m0_wdata;
          wstrb_d = gnt[1] ? m1_wstrb : m0_wstrb;
        end
      end
      ACCESS: begin
        state_d           = RESP;
        rvalid_d[owner_q] = 1'b1;
        err_d[owner_q]    = !s_addr_valid;
        if (owner_q) begin
          rdata1_d = resp_data_c;
        end else begin
          rdata0_d = resp_data_c;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: round-robin and fixed-priority instances share
// one stimulus stream and are checked every cycle against a transaction model.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] s_rdata = '0;
  logic        s_addr_valid = 1'b0;

  logic        g0 [2], g1 [2], rv0 [2], rv1 [2], er0 [2], er1 [2], sre [2], bsy [2];
  logic [31:0] rd0 [2], rd1 [2], saddr [2], swdata [2];
  logic [3:0]  swstrb [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  // Transaction model: age 0 = free, 1 = slave access cycle, 2 = response cycle
  int          age   [2] = '{0, 0};
  int          own   [2] = '{0, 0};
  int          prevw [2] = '{1, 1};
  logic [31:0] maddr [2], mwd [2];
  logic [3:0]  mws   [2];
  logic [31:0] mrd   [2][2] = '{'{0, 0}, '{0, 0}};
  logic        merr  [2][2] = '{'{0, 0}, '{0, 0}};

  int gw [2][16];
  int gt [2][16];
  int gn [2] = '{0, 0};

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    periph_bus_arbiter #(
      .ARB_MODE(i), .ADDR_W(32), .DATA_W(32)
    ) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(g0[i]), .m0_rvalid(rv0[i]), .m0_rdata(rd0[i]), .m0_err(er0[i]),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(g1[i]), .m1_rvalid(rv1[i]), .m1_rdata(rd1[i]), .m1_err(er1[i]),
      .s_addr(saddr[i]), .s_wdata(swdata[i]), .s_wstrb(swstrb[i]), .s_read_en(sre[i]),
      .s_rdata(s_rdata), .s_addr_valid(s_addr_valid), .busy(bsy[i])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of both instances against the model, then advance it
  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        int   w;
        logic acc;
        w = -1;
        if (!rst && age[k] == 0) begin
          if (m0_req && m1_req) w = (k == 1) ? 0 : 1 - prevw[k];
          else if (m0_req)      w = 0;
          else if (m1_req)      w = 1;
        end
        acc = (age[k] == 1) && !rst;
        chk($sformatf("m0_gnt[%0d]", k),    32'(g0[k]),     32'(w == 0));
        chk($sformatf("m1_gnt[%0d]", k),    32'(g1[k]),     32'(w == 1));
        chk($sformatf("busy[%0d]", k),      32'(bsy[k]),    32'(age[k] != 0));
        chk($sformatf("s_addr[%0d]", k),    saddr[k],       acc ? maddr[k] : 32'h0);
        chk($sformatf("s_wdata[%0d]", k),   swdata[k],      acc ? mwd[k] : 32'h0);
        chk($sformatf("s_wstrb[%0d]", k),   32'(swstrb[k]), acc ? 32'(mws[k]) : 32'h0);
        chk($sformatf("s_read_en[%0d]", k), 32'(sre[k]),    32'(acc && mws[k] == 4'h0));
        chk($sformatf("m0_rvalid[%0d]", k), 32'(rv0[k]),    32'(age[k] == 2 && own[k] == 0));
        chk($sformatf("m1_rvalid[%0d]", k), 32'(rv1[k]),    32'(age[k] == 2 && own[k] == 1));
        chk($sformatf("m0_rdata[%0d]", k),  rd0[k],         mrd[k][0]);
        chk($sformatf("m1_rdata[%0d]", k),  rd1[k],         mrd[k][1]);
        chk($sformatf("m0_err[%0d]", k),    32'(er0[k]),    32'(merr[k][0]));
        chk($sformatf("m1_err[%0d]", k),    32'(er1[k]),    32'(merr[k][1]));
        if ((g0[k] || g1[k]) && gn[k] < 16) begin
          gw[k][gn[k]] = g1[k] ? 1 : 0;
          gt[k][gn[k]] = cyc;
          gn[k]++;
        end
        if (rst) begin
          age[k]   = 0;
          prevw[k] = 1;
          mrd[k]   = '{0, 0};
          merr[k]  = '{0, 0};
        end else if (age[k] == 0 && w >= 0) begin
          own[k]   = w;
          prevw[k] = w;
          maddr[k] = (w == 1) ? m1_addr  : m0_addr;
          mwd[k]   = (w == 1) ? m1_wdata : m0_wdata;
          mws[k]   = (w == 1) ? m1_wstrb : m0_wstrb;
          age[k]   = 1;
        end else if (age[k] == 1) begin
          mrd[k][own[k]]  = (mws[k] == 4'h0 && s_addr_valid) ? s_rdata : 32'h0;
          merr[k][own[k]] = !s_addr_valid;
          age[k]          = 2;
        end else if (age[k] == 2) begin
          age[k] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    rst   = 1'b0;
    armed = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_busy[%0d]", k),  32'(bsy[k]), 32'h0);
      chk($sformatf("reset_rdata[%0d]", k), rd0[k],      32'h0);
    end

    // Master 0 read from the timer block
    step();
    m0_req = 1'b1; m0_addr = 32'h0200_BFF8; m0_wstrb = 4'h0;
    s_addr_valid = 1'b1; s_rdata = 32'h0000_1234;
    #1;
    chk("rd_gnt", 32'(g0[0]), 32'h1);
    step();
    m0_req = 1'b0;
    #1;
    chk("rd_read_en", 32'(sre[0]), 32'h1);
    chk("rd_s_addr", saddr[0], 32'h0200_BFF8);
    step();
    #1;
    chk("rd_rvalid", 32'(rv0[0]), 32'h1);
    chk("rd_rdata", rd0[0], 32'h0000_1234);
    chk("rd_read_en_off", 32'(sre[0]), 32'h0);
    step();
    #1;
    chk("rd_rvalid_pulse", 32'(rv0[0]), 32'h0);
    chk("rd_rdata_hold", rd0[0], 32'h0000_1234);

    // Master 1 full-word write
    m1_req = 1'b1; m1_addr = 32'h0200_4000; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
    #1;
    chk("wr_gnt", 32'(g1[0]), 32'h1);
    step();
    m1_req = 1'b0;
    #1;
    chk("wr_wstrb", 32'(swstrb[0]), 32'hF);
    chk("wr_wdata", swdata[0], 32'hDEAD_BEEF);
    step();
    #1;
    chk("wr_rvalid", 32'(rv1[0]), 32'h1);
    chk("wr_rdata", rd1[0], 32'h0);
    chk("wr_wstrb_off", 32'(swstrb[0]), 32'h0);
    chk("wr_m0_rdata_hold", rd0[0], 32'h0000_1234);
    step();

    // Both masters requesting back to back
    gn = '{0, 0};
    m0_req = 1'b1; m0_addr = 32'h0200_0000; m0_wstrb = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h0200_0004; m1_wstrb = 4'h0;
    s_rdata = 32'h0000_00A5;
    repeat (10) step();
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) step();
    chk("rr_grant_count", 32'(gn[0]), 32'd4);
    chk("fx_grant_count", 32'(gn[1]), 32'd4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rr_order%0d", j), 32'(gw[0][j]), 32'(j % 2));
      chk($sformatf("fx_order%0d", j), 32'(gw[1][j]), 32'h0);
      if (j > 0) chk($sformatf("rr_spacing%0d", j), 32'(gt[0][j] - gt[0][j-1]), 32'd3);
    end

    // Decode error: read data forced to zero
    m0_req = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
    s_addr_valid = 1'b0; s_rdata = 32'hAAAA_5555;
    step();
    m0_req = 1'b0;
    step();
    #1;
    chk("derr_rvalid", 32'(rv0[1]), 32'h1);
    chk("derr_err", 32'(er0[1]), 32'h1);
    chk("derr_rdata", rd0[1], 32'h0);
    step();

    // Partial strobe write passes through unchanged
    m0_req = 1'b1; m0_addr = 32'h0200_0010; m0_wdata = 32'h1122_3344; m0_wstrb = 4'h3;
    s_addr_valid = 1'b1;
    step();
    m0_req = 1'b0;
    #1;
    chk("part_wstrb", 32'(swstrb[0]), 32'h3);
    chk("part_read_en", 32'(sre[0]), 32'h0);
    step();
    #1;
    chk("part_err", 32'(er0[0]), 32'h0);
    step();

    // Reset during the access cycle of a write
    m0_req = 1'b1; m0_addr = 32'h0200_4000; m0_wdata = 32'h5A5A_5A5A; m0_wstrb = 4'hF;
    step();
    m0_req = 1'b0; rst = 1'b1;
    #1;
    chk("rst_wstrb_rr", 32'(swstrb[0]), 32'h0);
    chk("rst_wstrb_fx", 32'(swstrb[1]), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(bsy[0]), 32'h0);
    chk("rst_no_rvalid", 32'(rv0[0]), 32'h0);
    m0_req = 1'b1; m1_req = 1'b1; m0_wstrb = 4'h0; m1_wstrb = 4'h0;
    #1;
    chk("rst_tie_m0", 32'(g0[0]), 32'h1);
    chk("rst_tie_m1", 32'(g1[0]), 32'h0);
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
